// File: rtl/avalon_ram_burst.sv
// Avalon-MM RAM slave with incrementing read/write bursts and a fixed-latency,
// fully pipelined read return path. Memory contents are not reset.
module avalon_ram_burst #(
  parameter int unsigned ADW = 32,
  parameter int unsigned ABW = ADW / 8,
  parameter int unsigned ASZ = 1024,
  parameter int unsigned AAW = $clog2(ASZ / ABW),
  parameter int unsigned RLT = 2,
  parameter int unsigned BCW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           read,
  input  logic           write,
  input  logic [AAW-1:0] address,
  input  logic [ABW-1:0] byteenable,
  input  logic [BCW-1:0] burstcount,
  input  logic [ADW-1:0] writedata,
  output logic [ADW-1:0] readdata,
  output logic           readdatavalid,
  output logic           waitrequest
);

  localparam int unsigned Words = ASZ / ABW;

  typedef enum logic [1:0] {StIdle, StRburst, StWburst} state_e;

  state_e         state_q, state_d;
  logic [AAW-1:0] addr_q, addr_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [BCW-1:0] bc_eff;
  logic           wr_en, rd_en;
  logic [AAW-1:0] wr_addr, rd_addr;
  logic [ADW-1:0] mem_q [Words];
  logic [RLT-1:0] vld_q, vld_d;
  logic [ADW-1:0] data_q [RLT];
  logic [ADW-1:0] data_d [RLT];

  // A zero burstcount is a single-beat transfer.
  assign bc_eff = (burstcount == '0) ? BCW'(1) : burstcount;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_addr     = address;
    rd_en       = 1'b0;
    rd_addr     = address;
    waitrequest = 1'b0;
    case (state_q)
      StIdle: begin
        if (write) begin
          wr_en = 1'b1;
          if (bc_eff > BCW'(1)) begin
            addr_d  = address + AAW'(1);
            cnt_d   = bc_eff - BCW'(1);
            state_d = StWburst;
          end
        end else if (read) begin
          rd_en = 1'b1;
          if (bc_eff > BCW'(1)) begin
            addr_d  = address + AAW'(1);
            cnt_d   = bc_eff - BCW'(1);
            state_d = StRburst;
          end
        end
      end
      StWburst: begin
        if (write) begin
          wr_en   = 1'b1;
          wr_addr = addr_q;
          addr_d  = addr_q + AAW'(1);
          cnt_d   = cnt_q - BCW'(1);
          if (cnt_q == BCW'(1)) state_d = StIdle;
        end
      end
      StRburst: begin
        waitrequest = 1'b1;
        rd_en       = 1'b1;
        rd_addr     = addr_q;
        addr_d      = addr_q + AAW'(1);
        cnt_d       = cnt_q - BCW'(1);
        if (cnt_q == BCW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage data only moves when its valid moves, so the output holds between beats.
  always_comb begin
    vld_d[0]  = rd_en;
    data_d[0] = rd_en ? mem_q[rd_addr] : data_q[0];
    for (int unsigned i = 1; i < RLT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int unsigned i = 0; i < RLT; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  // Nonblocking write makes a same-edge read observe the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < ABW; i++) begin
        if (byteenable[i]) mem_q[wr_addr][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign readdata      = data_q[RLT-1];
  assign readdatavalid = vld_q[RLT-1];

endmodule

// File: doc/avalon_ram_burst.md
AVALON_RAM_BURST -- requirements
Module: avalon_ram_burst

Interface
REQ-001 Parameter ADW, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ABW, default ADW/8, byte enable width.
REQ-003 Parameter ASZ, default 1024, memory size in bytes; ASZ/ABW SHALL be a power of two.
REQ-004 Parameter AAW, default $clog2(ASZ/ABW), word address width.
REQ-005 Parameter RLT, default 2, read latency in cycles from command acceptance to readdatavalid; legal range 1..4.
REQ-006 Parameter BCW, default 4, burstcount width; maximum burst is 2**(BCW-1) words.
REQ-007 Ports SHALL be:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- read  in  1  read request
- write  in  1  write request
- address  in  AAW  word address
- byteenable  in  ABW  write byte lanes
- burstcount  in  BCW  burst length in words, sampled on the first beat only
- writedata  in  ADW  write data
- readdata  out  ADW  read data
- readdatavalid  out  1  readdata qualifier
- waitrequest  out  1  command stall

Function
REQ-008 The block SHALL hold ASZ/ABW words of ADW bits; memory contents SHALL NOT be reset.
REQ-009 The FSM SHALL have the states IDLE, RBURST and WBURST.
REQ-010 IDLE: waitrequest SHALL be 0; a command is accepted on any cycle with read or write high.
REQ-011 IDLE with write=1: the first beat SHALL be written on that clock edge to mem[address], per byte lane where byteenable[i]=1; if burstcount>1, the block SHALL latch address+1 and burstcount-1 and enter WBURST.
REQ-012 WBURST: waitrequest SHALL be 0; each cycle with write=1 SHALL write one beat to the latched address, then increment the address and decrement the count; the block SHALL return to IDLE after the final beat; cycles with write=0 SHALL stall the burst without side effects.
REQ-013 IDLE with read=1 and write=0: the block SHALL issue a read of mem[address]; if burstcount>1, it SHALL latch the next address and remaining count and enter RBURST.
REQ-014 RBURST: waitrequest SHALL be 1; the block SHALL issue one internal read per cycle at incrementing addresses and SHALL return to IDLE in the cycle after the last issue, with waitrequest going 0 in that cycle.
REQ-015 Each issued read SHALL produce readdata with readdatavalid=1 exactly RLT cycles after issue; a burst of N SHALL produce N consecutive valid cycles, in address order.
REQ-016 burstcount=0 SHALL be treated as 1.
REQ-017 The burst address SHALL wrap modulo ASZ/ABW (e.g., last word followed by word 0).
REQ-018 read and write both high in IDLE: the write SHALL be performed and the read ignored.
REQ-019 read=1 while in WBURST SHALL be ignored.
REQ-020 A read issued in the same cycle as a write to the same word SHALL return the old data (read-before-write).
REQ-021 readdata SHALL hold its last value while readdatavalid=0.
REQ-022 The readdatavalid pipeline SHALL be a RLT-deep shift register; reads SHALL be fully pipelined, so back-to-back single reads in IDLE sustain one word per cycle.

Reset
REQ-023 While rst=0: state=IDLE, waitrequest=0, readdatavalid=0, readdata=0, all pipeline valid bits cleared, burst address and count cleared.
REQ-024 Reset asserted mid-burst SHALL abort the burst; reads in flight SHALL never assert readdatavalid.
REQ-025 Reset deassertion SHALL be synchronous to clk; the first command SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-026 Single write 0xDEADBEEF to address 5, byteenable=4'b0011, over 0x00000000, then read 5 -> readdata=0x0000BEEF with readdatavalid high RLT cycles after the read.
REQ-027 Write burst of 4 at address 8 (data 1,2,3,4), then read burst of 4 at address 8 -> waitrequest high for 3 cycles; readdatavalid high for 4 consecutive cycles with data 1,2,3,4.
REQ-028 Read burst of 3 at address ASZ/ABW-2 -> data from words ASZ/ABW-2, ASZ/ABW-1 and 0.
REQ-029 Eight back-to-back single reads, RLT=3 -> waitrequest never high; eight consecutive valid cycles beginning 3 cycles after the first read.
REQ-030 Read burst of 8 with rst pulsed low during the 3rd issue cycle -> readdatavalid=0 until a new command is issued; state=IDLE; waitrequest=0.
REQ-031 read=write=1 in IDLE to address 2 -> word 2 written; no readdatavalid produced.
